// File: rtl/tdm_spike_encoder_pkg.sv
// Shared types and constants for the TDM spike encoder.
//   id_w()        : index width needed to address n neurons
//   ID_W          : index width for the default 500-neuron core
//   DROP_CNT_W    : width of the saturating drop counter
//   spike_event_t : {id, ts} event record at default widths
package tdm_spike_encoder_pkg;

  localparam int NEURON_COUNT_DEF = 500;
  localparam int TS_WIDTH_DEF     = 16;
  localparam int DROP_CNT_W       = 16;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W = id_w(NEURON_COUNT_DEF);

  typedef struct packed {
    logic [ID_W-1:0]         id;
    logic [TS_WIDTH_DEF-1:0] ts;
  } spike_event_t;

endpackage

// File: rtl/tdm_spike_encoder_if.sv
// Write-back beat input and spike event output of the encoder.
//   master : TDM core / downstream side (drives beats, thresh, ev_ready)
//   slave  : encoder side (drives ev_valid, ev_id, ev_ts)
interface tdm_spike_encoder_if #(
  parameter int ID_W       = 9,
  parameter int DATA_WIDTH = 16,
  parameter int TS_WIDTH   = 16
);
  logic                  wb_valid;
  logic [ID_W-1:0]       wb_id;
  logic [DATA_WIDTH-1:0] wb_v;
  logic [DATA_WIDTH-1:0] thresh;
  logic                  ev_valid;
  logic                  ev_ready;
  logic [ID_W-1:0]       ev_id;
  logic [TS_WIDTH-1:0]   ev_ts;

  modport master (output wb_valid, wb_id, wb_v, thresh, ev_ready,
                  input  ev_valid, ev_id, ev_ts);
  modport slave  (input  wb_valid, wb_id, wb_v, thresh, ev_ready,
                  output ev_valid, ev_id, ev_ts);
endinterface

// File: rtl/tdm_spike_encoder_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
//   push_i/wdata_i : write request; accepted when not full, or when full
//                    and a pop happens in the same cycle
//   pop_i          : remove head (ignored when empty)
//   rdata_o        : head entry (valid while !empty_o)
//   full_o/empty_o/level_o : occupancy status
module tdm_spike_encoder_sync_fifo #(
  parameter  int WIDTH = 25,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             wr, rd;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign rd      = pop_i & ~empty_o;
  assign wr      = push_i & (~full_o | rd);
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_comb begin
    level_d = level_q;
    case ({wr, rd})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Storage is not reset; the head is only observed while non-empty.
  always_ff @(posedge clk)
    if (wr) mem_q[wr_ptr_q] <= wdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/tdm_spike_encoder.sv
// Spike encoder on the TDM neuron write-back stream.
// Flags upward threshold crossings per neuron, stamps them with the sweep
// count and queues {id, ts} events for a valid/ready consumer.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : write-back beats in, spike events out (slave modport)
//   timestep   : completed-sweep count
//   drop_count : events lost to a full queue (saturating)
//   fifo_level : queued events
module tdm_spike_encoder
  import tdm_spike_encoder_pkg::*;
#(
  parameter  int NEURON_COUNT = 500,
  parameter  int DATA_WIDTH   = 16,
  parameter  int TS_WIDTH     = 16,
  parameter  int FIFO_DEPTH   = 16,
  localparam int NID_W        = id_w(NEURON_COUNT),
  localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  tdm_spike_encoder_if.slave    bus,
  output logic [TS_WIDTH-1:0]   timestep,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic [LVL_W-1:0]      fifo_level
);
  typedef struct packed {
    logic [NID_W-1:0]    id;
    logic [TS_WIDTH-1:0] ts;
  } ev_t;

  logic [NEURON_COUNT-1:0] above_q;
  logic                    spike_q;
  ev_t                     det_q, head;
  logic [TS_WIDTH-1:0]     ts_q;
  logic [DROP_CNT_W-1:0]   drop_q;
  logic                    beat_ok, last_beat, above_now, spike;
  logic                    fifo_full, fifo_empty, pop, drop;

  // Out-of-range ids are dropped before touching any state.
  assign beat_ok   = bus.wb_valid && (32'(bus.wb_id) < NEURON_COUNT);
  assign last_beat = beat_ok && (32'(bus.wb_id) == NEURON_COUNT - 1);
  assign above_now = $signed(bus.wb_v) >= $signed(bus.thresh);
  assign spike     = beat_ok & above_now & ~above_q[bus.wb_id];

  assign pop  = bus.ev_ready & ~fifo_empty;
  assign drop = spike_q & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      above_q <= '0;
      spike_q <= 1'b0;
      det_q   <= '0;
      ts_q    <= '0;
      drop_q  <= '0;
    end else begin
      if (beat_ok) above_q[bus.wb_id] <= above_now;
      spike_q  <= spike;
      det_q.id <= bus.wb_id;
      det_q.ts <= ts_q;           // pre-increment value for the last beat
      if (last_beat) ts_q <= ts_q + 1'b1;
      if (drop && drop_q != '1) drop_q <= drop_q + 1'b1;
    end
  end

  tdm_spike_encoder_sync_fifo #(.WIDTH($bits(ev_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (spike_q),
    .wdata_i (det_q),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Head is masked to zero when empty so the outputs never show stale storage.
  assign bus.ev_valid = ~fifo_empty;
  assign bus.ev_id    = fifo_empty ? '0 : head.id;
  assign bus.ev_ts    = fifo_empty ? '0 : head.ts;
  assign timestep     = ts_q;
  assign drop_count   = drop_q;
endmodule

// File: tb/tb_tdm_spike_encoder.sv
module tb_tdm_spike_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ts16, drop16, drop4;
  logic [3:0]  ts4;
  logic [4:0]  lvl16, lvl4;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tdm_spike_encoder_if #(.ID_W(9), .DATA_WIDTH(16), .TS_WIDTH(16)) bus ();
  tdm_spike_encoder_if #(.ID_W(9), .DATA_WIDTH(16), .TS_WIDTH(4))  bus4 ();

  // Narrow-timestamp instance sees the same stimulus to exercise wrap.
  assign bus4.wb_valid = bus.wb_valid;
  assign bus4.wb_id    = bus.wb_id;
  assign bus4.wb_v     = bus.wb_v;
  assign bus4.thresh   = bus.thresh;
  assign bus4.ev_ready = bus.ev_ready;

  tdm_spike_encoder #(.NEURON_COUNT(500), .DATA_WIDTH(16), .TS_WIDTH(16), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .timestep(ts16), .drop_count(drop16), .fifo_level(lvl16));

  tdm_spike_encoder #(.NEURON_COUNT(500), .DATA_WIDTH(16), .TS_WIDTH(4), .FIFO_DEPTH(16)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .timestep(ts4), .drop_count(drop4), .fifo_level(lvl4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input int id, input logic [15:0] v);
    bus.wb_valid = 1'b1;
    bus.wb_id    = 9'(id);
    bus.wb_v     = v;
    @(negedge clk);
    bus.wb_valid = 1'b0;
  endtask

  task automatic idle();
    bus.wb_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic sweep(input logic [15:0] v_last);
    for (int i = 0; i < 500; i++) beat(i, (i == 499) ? v_last : 16'h0000);
  endtask

  initial begin
    bus.wb_valid = 1'b0;
    bus.wb_id    = '0;
    bus.wb_v     = '0;
    bus.thresh   = 16'h0200;
    bus.ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_valid", 32'(bus.ev_valid), 0);
    chk("rst_id",    32'(bus.ev_id), 0);
    chk("rst_ts",    32'(bus.ev_ts), 0);
    chk("rst_tstep", 32'(ts16), 0);
    chk("rst_drop",  32'(drop16), 0);
    chk("rst_level", 32'(lvl16), 0);

    // 1: single crossing, two-cycle latency, no repeat while still above
    beat(7, 16'h0300);
    chk("t1_lat1", 32'(bus.ev_valid), 0);
    idle();
    chk("t1_valid", 32'(bus.ev_valid), 1);
    chk("t1_id",    32'(bus.ev_id), 7);
    chk("t1_ts",    32'(bus.ev_ts), 0);
    bus.ev_ready = 1'b1; idle(); bus.ev_ready = 1'b0;
    chk("t1_pop", 32'(lvl16), 0);
    beat(499, 16'h0000);
    chk("t1_tstep", 32'(ts16), 1);
    beat(7, 16'h0300); idle(); idle();
    chk("t1_norepeat", 32'(lvl16), 0);

    // 2: re-arm after dropping below; v == thresh counts as above
    beat(3, 16'h0300); beat(499, 16'h0000);
    beat(3, 16'h0100); beat(499, 16'h0000);
    beat(3, 16'h0200); idle(); idle();
    chk("t2_level", 32'(lvl16), 2);
    chk("t2_id0",   32'(bus.ev_id), 3);
    chk("t2_ts0",   32'(bus.ev_ts), 1);
    bus.ev_ready = 1'b1; idle(); bus.ev_ready = 1'b0;
    chk("t2_ts1",   32'(bus.ev_ts), 3);
    bus.ev_ready = 1'b1; idle(); bus.ev_ready = 1'b0;
    chk("t2_empty", 32'(lvl16), 0);

    // 3a: spike on the last beat of a sweep carries pre-increment ts
    sweep(16'h0300);
    chk("t3_tstep", 32'(ts16), 4);
    idle();
    chk("t3_id", 32'(bus.ev_id), 499);
    chk("t3_ts", 32'(bus.ev_ts), 3);
    bus.ev_ready = 1'b1; idle(); bus.ev_ready = 1'b0;

    // 4: overflow with stalled consumer, then drain in order
    for (int i = 10; i < 30; i++) beat(i, 16'h0300);
    idle(); idle();
    chk("t4_level", 32'(lvl16), 16);
    chk("t4_drop",  32'(drop16), 4);
    chk("t4_head",  32'(bus.ev_id), 10);
    idle();
    chk("t4_stable", 32'(bus.ev_id), 10);
    bus.ev_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t4_order", 32'(bus.ev_id), 32'(10 + i));
      idle();
    end
    bus.ev_ready = 1'b0;
    chk("t4_drained", 32'(lvl16), 0);

    // 5: push into a full FIFO in the same cycle as a pop
    for (int i = 30; i < 46; i++) beat(i, 16'h0300);
    idle(); idle();
    chk("t5_full", 32'(lvl16), 16);
    beat(46, 16'h0300);
    bus.ev_ready = 1'b1; idle(); bus.ev_ready = 1'b0;
    chk("t5_level", 32'(lvl16), 16);
    chk("t5_drop",  32'(drop16), 4);
    chk("t5_head",  32'(bus.ev_id), 31);

    // 6: reset with 5 queued events and one in flight
    bus.ev_ready = 1'b1;
    repeat (11) idle();
    bus.ev_ready = 1'b0;
    chk("t6_level5", 32'(lvl16), 5);
    beat(47, 16'h0300);
    rst = 1'b1; idle(); rst = 1'b0;
    chk("t6_valid", 32'(bus.ev_valid), 0);
    chk("t6_level", 32'(lvl16), 0);
    chk("t6_tstep", 32'(ts16), 0);
    chk("t6_drop",  32'(drop16), 0);
    idle();
    chk("t6_inflight", 32'(lvl16), 0);
    beat(7, 16'h0300); idle();
    chk("t6_respike", 32'(bus.ev_valid), 1);
    chk("t6_id",      32'(bus.ev_id), 7);
    bus.ev_ready = 1'b1; idle(); bus.ev_ready = 1'b0;
    beat(510, 16'h0300); idle(); idle();
    chk("t6_oor_ev",    32'(lvl16), 0);
    chk("t6_oor_tstep", 32'(ts16), 0);

    // 3b: 17 sweeps; the 4-bit timestamp wraps to 1
    bus.ev_ready = 1'b1;
    repeat (17) sweep(16'h0000);
    idle();
    chk("t3_tstep17", 32'(ts16), 17);
    chk("t3_wrap",    32'(ts4), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
